// File: rtl/msg_router.sv
// Byte-stream message router: hunts a two-byte sync word, reads an ID and a length,
// then steers each payload byte to one of NUM_SINKS unpackers via one-hot strobes.
module msg_router #(
   parameter int         NUM_SINKS = 4,
   parameter logic [7:0] SYNC0     = 8'h34,
   parameter logic [7:0] SYNC1     = 8'h12,
   parameter int         TIMEOUT   = 50000
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic [7:0]           ByteIn,
   input  logic                 ByteReady,
   output logic                 ClearAddr,
   output logic [NUM_SINKS-1:0] WriteByte,
   output logic [7:0]           DataByte,
   output logic [7:0]           MsgId,
   output logic                 MsgComplete,
   output logic                 BadId,
   output logic                 Timeout,
   output logic                 Busy
);

   localparam int             TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [7:0]     ID_LIMIT = 8'(NUM_SINKS);

   typedef enum logic [2:0] {HUNT, SYNC, GETID, GETCNT, PAYLOAD} state_t;

   state_t               state, state_next;
   logic [7:0]           remain, remain_next;
   logic [TW-1:0]        tcnt, tcnt_next;
   logic                 discard, discard_next;
   logic                 clear_next, complete_next, bad_next, timeout_next, busy_next;
   logic [NUM_SINKS-1:0] write_next;
   logic [7:0]           data_next, id_next;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= HUNT;
         remain      <= '0;
         tcnt        <= '0;
         discard     <= 1'b0;
         ClearAddr   <= 1'b0;
         WriteByte   <= '0;
         DataByte    <= '0;
         MsgId       <= '0;
         MsgComplete <= 1'b0;
         BadId       <= 1'b0;
         Timeout     <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         state       <= state_next;
         remain      <= remain_next;
         tcnt        <= tcnt_next;
         discard     <= discard_next;
         ClearAddr   <= clear_next;
         WriteByte   <= write_next;
         DataByte    <= data_next;
         MsgId       <= id_next;
         MsgComplete <= complete_next;
         BadId       <= bad_next;
         Timeout     <= timeout_next;
         Busy        <= busy_next;
      end
   end

   // A byte arriving always beats the timeout; idle cycles outside HUNT count toward it.
   always_comb begin
      state_next    = state;
      remain_next   = remain;
      tcnt_next     = '0;
      discard_next  = discard;
      clear_next    = 1'b0;
      write_next    = '0;
      data_next     = DataByte;
      id_next       = MsgId;
      complete_next = 1'b0;
      bad_next      = 1'b0;
      timeout_next  = 1'b0;

      if (ByteReady) begin
         case (state)
            HUNT: begin
               if (ByteIn == SYNC0) state_next = SYNC;
            end
            SYNC: begin
               if (ByteIn == SYNC1)      state_next = GETID;
               else if (ByteIn != SYNC0) state_next = HUNT;
            end
            GETID: begin
               id_next      = ByteIn;
               discard_next = (ByteIn >= ID_LIMIT);
               state_next   = GETCNT;
            end
            GETCNT: begin
               remain_next = ByteIn;
               clear_next  = 1'b1;
               bad_next    = discard;
               if (ByteIn == 8'd0) begin
                  complete_next = !discard;
                  state_next    = HUNT;
               end else begin
                  state_next = PAYLOAD;
               end
            end
            PAYLOAD: begin
               data_next   = ByteIn;
               if (!discard) write_next = NUM_SINKS'(1) << MsgId;
               remain_next = remain - 8'd1;
               if (remain == 8'd1) begin
                  complete_next = !discard;
                  state_next    = HUNT;
               end
            end
            default: state_next = HUNT;
         endcase
      end else if (state != HUNT) begin
         if (tcnt == T_LAST) begin
            timeout_next = 1'b1;
            state_next   = HUNT;
         end else begin
            tcnt_next = tcnt + TW'(1);
         end
      end

      busy_next = (state_next != HUNT);
   end

endmodule

// File: tb/tb_msg_router.sv
// Scoreboard bench for msg_router: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the router emits one.
module tb_msg_router;

   localparam int TMO = 40;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic [7:0] ByteIn = 8'h00;
   logic       ByteReady = 1'b0;
   logic       ClearAddr;
   logic [3:0] WriteByte;
   logic [7:0] DataByte;
   logic [7:0] MsgId;
   logic       MsgComplete;
   logic       BadId;
   logic       Timeout;
   logic       Busy;

   typedef struct packed {
      logic       clr;
      logic [3:0] wr;
      logic [7:0] data;
      logic       cmp;
      logic       bad;
      logic       tmo;
      logic [7:0] id;
   } evT;

   evT expQ[$];
   int testCount = 0;
   int failCount = 0;
   int eventCount = 0;

   msg_router #(.NUM_SINKS(4), .SYNC0(8'h34), .SYNC1(8'h12), .TIMEOUT(TMO)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .ByteIn(ByteIn), .ByteReady(ByteReady),
      .ClearAddr(ClearAddr), .WriteByte(WriteByte), .DataByte(DataByte), .MsgId(MsgId),
      .MsgComplete(MsgComplete), .BadId(BadId), .Timeout(Timeout), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   // Called just after a rising edge; the byte is sampled on the next rising edge.
   task automatic applyStimulus(input logic [7:0] b);
      ByteIn = b;
      ByteReady = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle(input int n);
      ByteReady = 1'b0;
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic expectEv(input logic clr, input logic [3:0] wr, input logic [7:0] data,
                           input logic cmp, input logic bad, input logic tmo, input logic [7:0] id);
      evT e;
      e = '{clr: clr, wr: wr, data: data, cmp: cmp, bad: bad, tmo: tmo, id: id};
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic sendSeq(input logic [7:0] bytes[$]);
      foreach (bytes[i]) applyStimulus(bytes[i]);
   endtask

   // Monitor: every cycle carrying a pulse or a write is one scoreboard event.
   initial begin
      evT e;
      logic ok;
      forever begin
         @(negedge Clock);
         if (Reset_n === 1'b1 && (ClearAddr || (|WriteByte) || MsgComplete || BadId || Timeout)) begin
            eventCount++;
            testCount++;
            if (expQ.size() == 0) begin
               failCount++;
               $display("[TB] FAIL unexpectedEvent%0d: got clr=%b wr=%b data=%h cmp=%b bad=%b tmo=%b id=%h, expected none",
                        eventCount, ClearAddr, WriteByte, DataByte, MsgComplete, BadId, Timeout, MsgId);
            end else begin
               e = expQ.pop_front();
               ok = (ClearAddr === e.clr) && (WriteByte === e.wr) && (MsgComplete === e.cmp) &&
                    (BadId === e.bad) && (Timeout === e.tmo) && (MsgId === e.id) &&
                    ((e.wr == 4'b0000) || (DataByte === e.data));
               if (!ok) begin
                  failCount++;
                  $display("[TB] FAIL event%0d: got clr=%b wr=%b data=%h cmp=%b bad=%b tmo=%b id=%h, expected clr=%b wr=%b data=%h cmp=%b bad=%b tmo=%b id=%h",
                           eventCount, ClearAddr, WriteByte, DataByte, MsgComplete, BadId, Timeout, MsgId,
                           e.clr, e.wr, e.data, e.cmp, e.bad, e.tmo, e.id);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge Clock);
      #1;
      checkOutput("rstClear", 32'(ClearAddr), 0);
      checkOutput("rstWrite", 32'(WriteByte), 0);
      checkOutput("rstData", 32'(DataByte), 0);
      checkOutput("rstMsgId", 32'(MsgId), 0);
      checkOutput("rstComplete", 32'(MsgComplete), 0);
      checkOutput("rstBadId", 32'(BadId), 0);
      checkOutput("rstTimeout", 32'(Timeout), 0);
      checkOutput("rstBusy", 32'(Busy), 0);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(posedge Clock);
      #1;

      // Reset asserted while a write strobe is active mid-payload
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h02);
      sendSeq('{8'h34, 8'h12, 8'h02, 8'h03, 8'hAA});
      checkOutput("preRstBusy", 32'(Busy), 1);
      ByteReady = 1'b0;
      Reset_n = 1'b0;
      #1;
      checkOutput("midRstWrite", 32'(WriteByte), 0);
      checkOutput("midRstData", 32'(DataByte), 0);
      checkOutput("midRstMsgId", 32'(MsgId), 0);
      checkOutput("midRstBusy", 32'(Busy), 0);
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      @(posedge Clock);
      #1;
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h00);
      expectEv(0, 4'b0001, 8'hAA, 0, 0, 0, 8'h00);
      expectEv(0, 4'b0001, 8'hBB, 1, 0, 0, 8'h00);
      sendSeq('{8'h34, 8'h12, 8'h00, 8'h02, 8'hAA, 8'hBB});
      idle(2);

      // Normal four-byte message to sink 2
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h02);
      expectEv(0, 4'b0100, 8'h11, 0, 0, 0, 8'h02);
      expectEv(0, 4'b0100, 8'h22, 0, 0, 0, 8'h02);
      expectEv(0, 4'b0100, 8'h33, 0, 0, 0, 8'h02);
      expectEv(0, 4'b0100, 8'h44, 1, 0, 0, 8'h02);
      sendSeq('{8'h34, 8'h12, 8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44});
      idle(3);
      checkOutput("normMsgId", 32'(MsgId), 32'h02);
      checkOutput("normDataHold", 32'(DataByte), 32'h44);
      checkOutput("normBusy", 32'(Busy), 0);

      // Resync on repeated SYNC0, then a rejected pair
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h01);
      expectEv(0, 4'b0010, 8'h5A, 1, 0, 0, 8'h01);
      sendSeq('{8'h34, 8'h34, 8'h12, 8'h01, 8'h01, 8'h5A});
      sendSeq('{8'h34, 8'h99});
      checkOutput("rejectBusy", 32'(Busy), 0);
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h03);
      expectEv(0, 4'b1000, 8'h77, 1, 0, 0, 8'h03);
      sendSeq('{8'h34, 8'h12, 8'h03, 8'h01, 8'h77});
      idle(2);

      // Bad ID: payload swallowed, then a valid message
      expectEv(1, 4'b0000, 8'h00, 0, 1, 0, 8'h07);
      sendSeq('{8'h34, 8'h12, 8'h07, 8'h03, 8'hDE, 8'hAD, 8'hBE});
      checkOutput("badIdBusy", 32'(Busy), 0);
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h00);
      expectEv(0, 4'b0001, 8'hC3, 1, 0, 0, 8'h00);
      sendSeq('{8'h34, 8'h12, 8'h00, 8'h01, 8'hC3});
      idle(2);

      // Zero length, then a timeout mid-payload
      expectEv(1, 4'b0000, 8'h00, 1, 0, 0, 8'h00);
      sendSeq('{8'h34, 8'h12, 8'h00, 8'h00});
      idle(2);
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h01);
      expectEv(0, 4'b0010, 8'hAA, 0, 0, 0, 8'h01);
      expectEv(0, 4'b0000, 8'h00, 0, 0, 1, 8'h01);
      sendSeq('{8'h34, 8'h12, 8'h01, 8'h05, 8'hAA});
      idle(TMO - 3);
      checkOutput("tmoStillBusy", 32'(Busy), 1);
      idle(6);
      checkOutput("tmoBusyDropped", 32'(Busy), 0);

      // Full-rate 255-byte payload to sink 3
      expectEv(1, 4'b0000, 8'h00, 0, 0, 0, 8'h03);
      sendSeq('{8'h34, 8'h12, 8'h03, 8'hFF});
      for (int i = 1; i <= 255; i++) begin
         expectEv(0, 4'b1000, 8'(i), (i == 255), 0, 0, 8'h03);
         applyStimulus(8'(i));
         if (i == 254) checkOutput("fullBusyBeforeLast", 32'(Busy), 1);
      end
      checkOutput("fullBusyAfterLast", 32'(Busy), 0);
      idle(4);

      checkOutput("pendingExpected", 32'(expQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
